sprite_motion_ctrl: RTL and testbench

SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

---
 rtl/vga_pkg.sv | 14 +
 rtl/btn_sync.sv | 26 ++
 rtl/sprite_motion_ctrl.sv | 152 +++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry and motion FSM state shared by the sprite blocks.
// No ports; imported with import vga_pkg::*.
package vga_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    COMMIT
  } state_e;

endpackage

// File: rtl/btn_sync.sv
// btn_sync: two-flop synchronizer for one asynchronous active-low button.
// Ports: i_clk, i_rst (sync, active high), i_btn_n (async), o_btn_n (synced).
module btn_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_btn_n
);

  logic r_meta;
  logic r_sync;

  // Reset parks both flops at the released level so no phantom press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_btn_n;
      r_sync <= r_meta;
    end
  end

  assign o_btn_n = r_sync;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: once-per-frame sprite position update from buttons.
// Ports: iVGA_CLK, iRST (sync high), iVS (low vsync), mLeft/mRight/mUp/mDown
//   (async low), iEnable -> oPosX, oPosY, oTopLeft, oFrameTick, oMoving.
// Build option: define SPRITE_ACCEL_EN for the hold-to-accelerate step.
module sprite_motion_ctrl
  import vga_pkg::*;
#(
  parameter int SPRITE_W = 50,
  parameter int SPRITE_H = 50,
  parameter int STEP     = 1,
  parameter int X0       = 40,
  parameter int Y0       = 1
) (
  input  logic        iVGA_CLK,
  input  logic        iRST,
  input  logic        iVS,
  input  logic        mLeft,
  input  logic        mRight,
  input  logic        mUp,
  input  logic        mDown,
  input  logic        iEnable,
  output logic [9:0]  oPosX,
  output logic [8:0]  oPosY,
  output logic [18:0] oTopLeft,
  output logic        oFrameTick,
  output logic        oMoving
);

  localparam logic signed [10:0] XMAX = 11'(SCREEN_W - SPRITE_W);
  localparam logic signed [10:0] YMAX = 11'(SCREEN_H - SPRITE_H);
  localparam logic [18:0] TL0 = 19'(Y0 * SCREEN_W + X0);

  logic w_l_n, w_r_n, w_u_n, w_d_n;

  btn_sync u_left  (.i_clk(iVGA_CLK), .i_rst(iRST),
                    .i_btn_n(mLeft),  .o_btn_n(w_l_n));
  btn_sync u_right (.i_clk(iVGA_CLK), .i_rst(iRST),
                    .i_btn_n(mRight), .o_btn_n(w_r_n));
  btn_sync u_up    (.i_clk(iVGA_CLK), .i_rst(iRST),
                    .i_btn_n(mUp),    .o_btn_n(w_u_n));
  btn_sync u_down  (.i_clk(iVGA_CLK), .i_rst(iRST),
                    .i_btn_n(mDown),  .o_btn_n(w_d_n));

  // Disable gates the presses, which yields dx = dy = 0.
  logic w_l, w_r, w_u, w_d;
  assign w_l = ~w_l_n & iEnable;
  assign w_r = ~w_r_n & iEnable;
  assign w_u = ~w_u_n & iEnable;
  assign w_d = ~w_d_n & iEnable;

  state_e r_state;
  logic   r_vs;
  logic   r_vs_d;
  logic [9:0] r_nx;
  logic [8:0] r_ny;
  logic       r_mv;
  logic [10:0] w_step;

`ifdef SPRITE_ACCEL_EN
  logic [5:0] r_hold;
  logic [3:0] r_dir_c;
  logic [3:0] r_dir_l;
  logic [3:0] w_dir;

  assign w_dir  = {w_r & ~w_l, w_l & ~w_r, w_d & ~w_u, w_u & ~w_d};
  assign w_step = (r_hold == 6'd32) ? 11'(2 * STEP) : 11'(STEP);

  // Counts commits that repeat the same nonzero direction.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_hold  <= '0;
      r_dir_c <= '0;
      r_dir_l <= '0;
    end else if (r_state == CALC) begin
      r_dir_c <= w_dir;
    end else if (r_state == COMMIT) begin
      r_dir_l <= r_dir_c;
      if (r_dir_c == 4'd0)
        r_hold <= '0;
      else if (r_dir_c != r_dir_l)
        r_hold <= 6'd1;
      else if (r_hold != 6'd32)
        r_hold <= r_hold + 6'd1;
    end
  end
`else
  assign w_step = 11'(STEP);
`endif

  logic signed [10:0] w_dx, w_dy, w_sx, w_sy;
  logic [9:0] w_nx;
  logic [8:0] w_ny;

  always_comb begin
    w_dx = '0;
    w_dy = '0;
    if (w_r && !w_l) w_dx = w_step;
    else if (w_l && !w_r) w_dx = -w_step;
    if (w_d && !w_u) w_dy = w_step;
    else if (w_u && !w_d) w_dy = -w_step;
    w_sx = $signed({1'b0, oPosX}) + w_dx;
    w_sy = $signed({2'b0, oPosY}) + w_dy;
    w_nx = w_sx[9:0];
    w_ny = w_sy[8:0];
    if (w_sx < 0) w_nx = '0;
    else if (w_sx > XMAX) w_nx = XMAX[9:0];
    if (w_sy < 0) w_ny = '0;
    else if (w_sy > YMAX) w_ny = YMAX[8:0];
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_state    <= IDLE;
      r_vs       <= 1'b1;
      r_vs_d     <= 1'b1;
      oFrameTick <= 1'b0;
      oPosX      <= 10'(X0);
      oPosY      <= 9'(Y0);
      oTopLeft   <= TL0;
      oMoving    <= 1'b0;
      r_nx       <= 10'(X0);
      r_ny       <= 9'(Y0);
      r_mv       <= 1'b0;
    end else begin
      r_vs       <= iVS;
      r_vs_d     <= r_vs;
      oFrameTick <= r_vs_d & ~r_vs;
      unique case (r_state)
        IDLE: begin
          if (oFrameTick) r_state <= CALC;
        end
        CALC: begin
          r_nx    <= w_nx;
          r_ny    <= w_ny;
          r_mv    <= (w_nx != oPosX) || (w_ny != oPosY);
          r_state <= COMMIT;
        end
        COMMIT: begin
          oPosX    <= r_nx;
          oPosY    <= r_ny;
          oMoving  <= r_mv;
          // y*640 as y*512 + y*128
          oTopLeft <= ({10'd0, r_ny} << 9) + ({10'd0, r_ny} << 7)
                    + {9'd0, r_nx};
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed and random frames against a position model.
// Summary: Simulation finished: <checks> checks, <errors> errors
module tb_sprite_motion_ctrl;

  localparam int XMAX = 640 - 50;
  localparam int YMAX = 480 - 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, vs, l_n, r_n, u_n, d_n, en;
  logic [9:0]  px;
  logic [8:0]  py;
  logic [18:0] tl;
  logic        tick, mov;

  sprite_motion_ctrl dut (
    .iVGA_CLK  (clk),
    .iRST      (rst),
    .iVS       (vs),
    .mLeft     (l_n),
    .mRight    (r_n),
    .mUp       (u_n),
    .mDown     (d_n),
    .iEnable   (en),
    .oPosX     (px),
    .oPosY     (py),
    .oTopLeft  (tl),
    .oFrameTick(tick),
    .oMoving   (mov)
  );

  int n_checks = 0;
  int n_errors = 0;

  int mx, my, mhold, mlx, mly;
  bit mmov;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 40; my = 1; mhold = 0; mlx = 0; mly = 0; mmov = 0;
  endtask

  function automatic int dir(input bit neg, input bit pos, input bit e);
    if (!e) return 0;
    if (pos && !neg) return 1;
    if (neg && !pos) return -1;
    return 0;
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_step(input bit l, r, u, d, e);
    int xd, yd, st, nx, ny;
    xd = dir(l, r, e);
    yd = dir(u, d, e);
    st = 1;
`ifdef SPRITE_ACCEL_EN
    if (mhold == 32) st = 2;
    if (xd == 0 && yd == 0) mhold = 0;
    else if (xd != mlx || yd != mly) mhold = 1;
    else if (mhold < 32) mhold++;
    mlx = xd; mly = yd;
`endif
    nx = clamp(mx + xd * st, XMAX);
    ny = clamp(my + yd * st, YMAX);
    mmov = (nx != mx) || (ny != my);
    mx = nx; my = ny;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_x"},   px,   mx);
    check({tag, "_y"},   py,   my);
    check({tag, "_tl"},  tl,   my * 640 + mx);
    check({tag, "_mov"}, mov,  mmov);
  endtask

  task automatic set_btn(input bit l, r, u, d, e);
    l_n = !l; r_n = !r; u_n = !u; d_n = !d; en = e;
  endtask

  task automatic wait_tick(output bit got);
    got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tick) begin
        got = 1;
        break;
      end
    end
    check("tick_seen", got, 1);
  endtask

  task automatic frame(input bit l, r, u, d, e);
    bit got;
    int ox, oy;
    set_btn(l, r, u, d, e);
    repeat (4) @(negedge clk);
    vs = 0;
    wait_tick(got);
    if (got) begin
      ox = mx; oy = my;
      @(negedge clk);
      check("tick_width", tick, 0);
      @(negedge clk);
      check("pre_commit_x", px, ox);
      check("pre_commit_y", py, oy);
      model_step(l, r, u, d, e);
      @(negedge clk);
      check_outputs("commit");
    end
    vs = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    bit got;
    int guard;
    int prev;
    rst = 1; vs = 1; set_btn(0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    rst = 0;
    model_reset();
    check_outputs("reset");
    check("reset_tick", tick, 0);

    for (int k = 0; k < 3; k++) frame(0, 1, 0, 0, 1);
    check("right3_x", px, 43);
    check("right3_tl", tl, 683);

    frame(1, 1, 0, 0, 1);
    check("lr_both_x", px, 43);
    check("lr_both_mov", mov, 0);

    frame(0, 1, 0, 0, 0);
    check("disabled_x", px, 43);

    frame(0, 0, 1, 0, 1);
    frame(0, 0, 1, 0, 1);
    check("top_clamp_y", py, 0);
    check("top_clamp_mov", mov, 0);

    guard = 0;
    while (mx < XMAX && guard < 700) begin
      frame(0, 1, 0, 0, 1);
      guard++;
    end
    frame(0, 1, 0, 0, 1);
    check("right_clamp_x", px, 590);
    check("right_clamp_mov", mov, 0);

    pulse_reset();
    set_btn(0, 0, 0, 1, 1);
    repeat (4) @(negedge clk);
    vs = 0;
    wait_tick(got);
    if (got) begin
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      model_reset();
      check_outputs("rst_in_commit");
    end
    vs = 1;
    set_btn(0, 0, 0, 0, 1);
    repeat (4) @(negedge clk);

    for (int k = 1; k <= 40; k++) begin
      prev = my;
      frame(0, 0, 0, 1, 1);
`ifdef SPRITE_ACCEL_EN
      check("hold_down_inc", py - prev, (k >= 33) ? 2 : 1);
`else
      check("hold_down_inc", py - prev, 1);
`endif
    end

    for (int k = 0; k < 80; k++) begin
      frame($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
